nn_argmax_classifier: RTL and testbench

- Downstream of the network top. Consumes the 10 registered, activated layer-3 scores and produces the predicted digit class.
- Reports the winning score, the runner-up score, their margin, and a confidence flag.
- Scans one class per cycle under a start/busy/done handshake. Results are held stable until the next start, so a host or display stage can read them at leisure.

---
 rtl/nn_argmax_classifier_pkg.sv | 18 +
 rtl/nn_argmax_classifier_argmax_update.sv | 36 +++
 rtl/nn_argmax_classifier.sv | 139 +++++++++++++
 tb/tb_nn_argmax_classifier.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nn_argmax_classifier_pkg.sv
// Shared definitions for the argmax classifier.
// Holds the default sizing constants, the FSM state encoding and the
// most-negative score used to seed the runner-up tracker.
package nn_argmax_classifier_pkg;

    localparam int N_CLASSES = 10;
    localparam int WIDTH     = 16;
    localparam int IDX_W     = 4;

    localparam logic signed [WIDTH-1:0] MIN_SCORE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nn_argmax_classifier_argmax_update.sv
// argmax_update: combinational update of the running (best, best_idx, second)
// triple against one candidate score s_i at index k_i.
// Ports:
//   best_i, best_idx_i, second_i : current running state
//   s_i, k_i                     : candidate score and its class index
//   best_o, best_idx_o, second_o : updated running state
// Compares are signed and strict, so on a tie the earlier (lower) index keeps
// the max while the equal value can still displace the runner-up.
module argmax_update #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic signed [WIDTH-1:0] best_i,
    input  logic        [IDX_W-1:0] best_idx_i,
    input  logic signed [WIDTH-1:0] second_i,
    input  logic signed [WIDTH-1:0] s_i,
    input  logic        [IDX_W-1:0] k_i,
    output logic signed [WIDTH-1:0] best_o,
    output logic        [IDX_W-1:0] best_idx_o,
    output logic signed [WIDTH-1:0] second_o
);

    always_comb begin
        best_o     = best_i;
        best_idx_o = best_idx_i;
        second_o   = second_i;
        if (s_i > best_i) begin
            second_o   = best_i;
            best_o     = s_i;
            best_idx_o = k_i;
        end else if (s_i > second_i) begin
            second_o = s_i;
        end
    end

endmodule

// File: rtl/nn_argmax_classifier.sv
// nn_argmax_classifier: sequential argmax over N_CLASSES signed scores.
// On an accepted start the score bus is snapshotted, then one class is
// scanned per cycle. Results are held until the next accepted start.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   start              : request a run (only honoured in IDLE)
//   scores             : flat signed score bus, class g at [g*WIDTH +: WIDTH]
//   busy, done, valid  : handshake status (done is a one-cycle pulse)
//   class_idx          : index of the maximum score
//   max_score          : maximum score
//   second_score       : runner-up score
//   margin             : max_score - second_score, one bit wider, never negative
//   confident          : margin >= THRESHOLD
module nn_argmax_classifier
    import nn_argmax_classifier_pkg::*;
#(
    parameter int               N_CLASSES = nn_argmax_classifier_pkg::N_CLASSES,
    parameter int               WIDTH     = nn_argmax_classifier_pkg::WIDTH,
    parameter int               IDX_W     = nn_argmax_classifier_pkg::IDX_W,
    parameter logic [WIDTH:0]   THRESHOLD = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [N_CLASSES*WIDTH-1:0]    scores,
    output logic                          busy,
    output logic                          done,
    output logic                          valid,
    output logic [IDX_W-1:0]              class_idx,
    output logic signed [WIDTH-1:0]       max_score,
    output logic signed [WIDTH-1:0]       second_score,
    output logic [WIDTH:0]                margin,
    output logic                          confident
);

    localparam logic signed [WIDTH-1:0] MIN_S   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]        LAST_K  = IDX_W'(N_CLASSES - 1);

    state_e                  state_q;
    logic [IDX_W-1:0]        k_q;
    logic signed [WIDTH-1:0] snap_q [N_CLASSES];
    logic signed [WIDTH-1:0] best_q, second_q;
    logic [IDX_W-1:0]        best_idx_q;

    logic signed [WIDTH-1:0] best_d, second_d;
    logic [IDX_W-1:0]        best_idx_d;
    logic [WIDTH:0]          margin_d;

    logic                    busy_q, done_q, valid_q, confident_q;
    logic [IDX_W-1:0]        class_idx_q;
    logic signed [WIDTH-1:0] max_score_q, second_score_q;
    logic [WIDTH:0]          margin_q;

    argmax_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_update (
        .best_i     (best_q),
        .best_idx_i (best_idx_q),
        .second_i   (second_q),
        .s_i        (snap_q[k_q]),
        .k_i        (k_q),
        .best_o     (best_d),
        .best_idx_o (best_idx_d),
        .second_o   (second_d)
    );

    // Sign-extend both operands by one bit so the full signed range
    // difference (up to 2^WIDTH - 1) fits without wrapping.
    assign margin_d = {best_q[WIDTH-1], best_q} - {second_q[WIDTH-1], second_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            best_q         <= '0;
            best_idx_q     <= '0;
            second_q       <= '0;
            for (int g = 0; g < N_CLASSES; g++) snap_q[g] <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            valid_q        <= 1'b0;
            confident_q    <= 1'b0;
            class_idx_q    <= '0;
            max_score_q    <= '0;
            second_score_q <= '0;
            margin_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int g = 0; g < N_CLASSES; g++)
                            snap_q[g] <= scores[g*WIDTH +: WIDTH];
                        best_q     <= scores[WIDTH-1:0];
                        best_idx_q <= '0;
                        second_q   <= MIN_S;
                        k_q        <= IDX_W'(1);
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    second_q   <= second_d;
                    if (k_q == LAST_K) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    class_idx_q    <= best_idx_q;
                    max_score_q    <= best_q;
                    second_score_q <= second_q;
                    margin_q       <= margin_d;
                    confident_q    <= (margin_d >= THRESHOLD);
                    done_q         <= 1'b1;
                    valid_q        <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign valid        = valid_q;
    assign class_idx    = class_idx_q;
    assign max_score    = max_score_q;
    assign second_score = second_score_q;
    assign margin       = margin_q;
    assign confident    = confident_q;

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Directed self-checking bench for nn_argmax_classifier.
module tb_nn_argmax_classifier;

    localparam int NC = 10;
    localparam int W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NC*W-1:0]   scores;
    logic              busy, done, valid, confident;
    logic [3:0]        class_idx;
    logic signed [W-1:0] max_score, second_score;
    logic [W:0]        margin;

    int passed = 0;
    int total  = 0;
    int n;
    logic busy_ok;
    logic no_done;

    nn_argmax_classifier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .scores       (scores),
        .busy         (busy),
        .done         (done),
        .valid        (valid),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .second_score (second_score),
        .margin       (margin),
        .confident    (confident)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_all(input int v);
        for (int g = 0; g < NC; g++) scores[g*W +: W] = s16(v);
    endtask

    task automatic set_one(input int g, input int v);
        scores[g*W +: W] = s16(v);
    endtask

    // Caller is #1 past an edge; start is sampled at the next edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded; busy must hold until then.
    task automatic wait_done(output int cnt, output logic bok);
        cnt = 0;
        bok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (done) break;
            if (!busy) bok = 1'b0;
        end
        if (!done) cnt = -1;
    endtask

    task automatic check_result(input string tag, input int idx, input int mx,
                                input int sc, input int mg, input int cf);
        check({tag, ".done"},   {31'b0, done},  32'd1);
        check({tag, ".valid"},  {31'b0, valid}, 32'd1);
        check({tag, ".idx"},    {28'b0, class_idx}, idx);
        check({tag, ".max"},    {16'b0, max_score}, {16'b0, s16(mx)});
        check({tag, ".second"}, {16'b0, second_score}, {16'b0, s16(sc)});
        check({tag, ".margin"}, {15'b0, margin}, mg);
        check({tag, ".conf"},   {31'b0, confident}, cf);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        scores = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy",   {31'b0, busy}, 0);
        check("rst.done",   {31'b0, done}, 0);
        check("rst.valid",  {31'b0, valid}, 0);
        check("rst.conf",   {31'b0, confident}, 0);
        check("rst.idx",    {28'b0, class_idx}, 0);
        check("rst.max",    {16'b0, max_score}, 0);
        check("rst.second", {16'b0, second_score}, 0);
        check("rst.margin", {15'b0, margin}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic mixed vector
        set_one(0, 5);  set_one(1, 9); set_one(2, -3); set_one(3, 12); set_one(4, 0);
        set_one(5, 7);  set_one(6, 1); set_one(7, 2);  set_one(8, 3);  set_one(9, 4);
        pulse_start();
        check("t1.busy0", {31'b0, busy}, 1);
        wait_done(n, busy_ok);
        check("t1.latency", n, 10);
        check("t1.busyheld", {31'b0, busy_ok}, 1);
        check_result("t1", 3, 12, 9, 3, 0);
        @(posedge clk); #1;
        check("t1.donepulse", {31'b0, done}, 0);
        check("t1.validhold", {31'b0, valid}, 1);
        check("t1.busyoff", {31'b0, busy}, 0);

        // Clear winner above threshold
        set_all(100); set_one(7, 600);
        pulse_start();
        wait_done(n, busy_ok);
        check("t2.latency", n, 10);
        check_result("t2", 7, 600, 100, 500, 1);

        // Tie: lower index wins the max, equal value becomes second
        set_all(-10); set_one(2, 50); set_one(8, 50);
        pulse_start();
        wait_done(n, busy_ok);
        check("t3.latency", n, 10);
        check_result("t3", 2, 50, 50, 0, 0);

        // Extremes of the signed range
        set_all(-32768); set_one(9, 32767);
        pulse_start();
        wait_done(n, busy_ok);
        check("t4.latency", n, 10);
        check_result("t4", 9, 32767, -32768, 65535, 1);

        // Start re-pulsed mid-scan with a different bus: ignored
        set_all(1); set_one(4, 40); set_one(6, 30);
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        set_all(0); set_one(1, 1000);
        pulse_start();
        wait_done(n, busy_ok);
        check("t5.latency", n, 6);
        check_result("t5", 4, 40, 30, 10, 0);

        // Back-to-back start in the cycle right after done (bus holds idx1=1000)
        pulse_start();
        check("t6.validdrop", {31'b0, valid}, 0);
        check("t6.busy", {31'b0, busy}, 1);
        wait_done(n, busy_ok);
        check("t6.latency", n, 10);
        check_result("t6", 1, 1000, 0, 1000, 1);

        // Reset together with start at scan cycle 4 aborts the run
        set_all(3); set_one(5, 900);
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check("t7.busy",   {31'b0, busy}, 0);
        check("t7.valid",  {31'b0, valid}, 0);
        check("t7.idx",    {28'b0, class_idx}, 0);
        check("t7.max",    {16'b0, max_score}, 0);
        check("t7.margin", {15'b0, margin}, 0);
        no_done = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) no_done = 1'b0;
        end
        check("t7.nodone", {31'b0, no_done}, 1);
        pulse_start();
        wait_done(n, busy_ok);
        check("t7.latency", n, 10);
        check_result("t7", 5, 900, 3, 897, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
